storage_arbiter: RTL
====================

# storage_arbiter

Two-port arbiter that shares the single `storage_controller` between the core's instruction-fetch port and its data port. It accepts Ibex-style req/gnt/rvalid transactions and decodes each word address to on-chip SRAM or external QSPI flash. It sequences exactly one downstream access at a time and returns read data or an error to the originating port. It sits between the core memory interfaces and `storage_controller`, and blocks new grants while programming mode is active.

## Interface
- `SRAM_WORDS`, 2048: SRAM words; word address `< SRAM_WORDS` → SRAM, otherwise external flash.
- `WRITE_CYCLES`, 1: cycles `memory_access` is held for an SRAM write (writes do not wait for `out_valid`).
- `TIMEOUT`, 1024: maximum cycles waiting for `out_valid` before an error response.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `set_programming_mode`  in  1  high → no new grants.
- `instr_req`, `instr_addr`  in  1, 32  fetch request, word address (read-only port).
- `instr_gnt`, `instr_rvalid`, `instr_err`  out  1 each  grant, response valid, error.
- `instr_rdata`  out  32  fetch data.
- `data_req`, `data_we`  in  1 each  data request, write enable.
- `data_be`  in  4  byte enables.
- `data_addr`, `data_wdata`  in  32 each  word address, write data.
- `data_gnt`, `data_rvalid`, `data_err`  out  1 each.
- `data_rdata`  out  32.
- `memory_access`, `memory_is_writing`, `external_storage_access`  out  1 each  to storage_controller.
- `addr`, `d_in`  out  32 each; `mem_be`  out  4.
- `d_out`  in  32; `out_valid`  in  1  from storage_controller.

## Operation
- FSM states: IDLE, READ_WAIT, WRITE_HOLD, RESP.
- IDLE with `set_programming_mode`=0 and at least one req: grant one port (combinational `*_gnt`, same cycle).
  - Both ports requesting: grant the port not granted last (round-robin). `last` resets to data, so instr wins the first tie.
- Grant captures addr/we/be/wdata into registers and decodes: `ext = (addr >= SRAM_WORDS)`.
- Legal read → READ_WAIT. SRAM write → WRITE_HOLD. Write with `ext`=1 is illegal → RESP with err, no downstream access.
- READ_WAIT: drive `memory_access`=1 and `external_storage_access`=ext. On `out_valid`, capture `d_out` → RESP. Counter reaching `TIMEOUT` → RESP with err.
- WRITE_HOLD: drive `memory_access`=1, `memory_is_writing`=1, `d_in`, `mem_be` for `WRITE_CYCLES` cycles → RESP. Writes return rvalid with rdata=0.
- RESP: pulse `*_rvalid` (and `*_err` if flagged) to the owning port for 1 cycle, then → IDLE.
- `set_programming_mode` rising mid-transaction: the in-flight transaction completes normally; no grants afterwards until it drops.
- Downstream `addr`, `d_in` and `mem_be` are 0 whenever `memory_access`=0.

## Timing
- Reset (async, `rst`=0): state IDLE; all outputs 0; counter 0; `last`=data. An in-flight access is abandoned, with no response.
- Request with gnt at cycle N:
  - `memory_access` high from N+1.
  - `out_valid` sampled high at cycle M: `memory_access` drops at M+1 and `*_rvalid` is high at M+1 with rdata = `d_out` from M.
  - IDLE at M+2; the next grant is possible at M+2.
- Read latency: `M-N+1` cycles. Minimum when `out_valid` arrives at N+1: rvalid at N+2.
- SRAM write: `memory_access` high N+1..N+WRITE_CYCLES; rvalid at N+WRITE_CYCLES+1.
- Illegal external write: rvalid and err at N+1; no downstream activity.
- Timeout: counter starts at N+1. After `TIMEOUT` cycles without `out_valid`, rvalid and err are asserted the next cycle.
- `out_valid` outside READ_WAIT is ignored.
- `*_gnt` is only ever asserted in IDLE and only to one port per cycle. Both ports share the `rdata`/`rvalid` timing rule; only the owner's signals toggle.

## Test plan
- Instr-only read, addr 0x10 (SRAM), stub `out_valid` 3 cycles after access: `instr_rvalid` 1 cycle later, rdata = stub value, `external_storage_access`=0.
- Data write to addr 0x7FF with wdata 0xA5A5A5A5, be 0xF, then read back: one write access with `memory_is_writing`=1, then read rdata = 0xA5A5A5A5.
- Both ports request reads continuously for 8 transactions: grants alternate instr, data, instr, …, starting with instr.
- Data read at addr 0x800: `external_storage_access`=1. Data write at 0x800: `data_err`=1, and `memory_access` never rises.
- Read with `out_valid` held low and TIMEOUT=16: err response 17 cycles after `memory_access` rises, then the next request is granted.
- Assert `set_programming_mode` during READ_WAIT, then assert `rst`=0 mid-read on a second run:
  - First run: the read completes, and no grants are made while mode is high.
  - Second run: all outputs 0 immediately, with no rvalid.

Source files
------------

// File: rtl/storage_arbiter.sv
// storage_arbiter: shares one storage_controller between the instruction-fetch
// port and the data port. Each granted request is decoded to SRAM or external
// flash and run as a single downstream access. The result goes back to the
// port that issued the request. No new grants are made while programming mode
// is active.
module storage_arbiter #(
  parameter int SRAM_WORDS   = 2048,
  parameter int WRITE_CYCLES = 1,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_programming_mode,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output logic        instr_err,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic        data_err,
  output logic [31:0] data_rdata,
  output logic        memory_access,
  output logic        memory_is_writing,
  output logic        external_storage_access,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic [3:0]  mem_be,
  input  logic [31:0] d_out,
  input  logic        out_valid
);

  localparam int          CNT_MAX    = (TIMEOUT > WRITE_CYCLES) ? TIMEOUT : WRITE_CYCLES;
  localparam int          CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [31:0] SRAM_LIMIT = SRAM_WORDS;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_HOLD, RESP} state_t;

  state_t             state, state_nxt;
  logic               owner_data;   // 1: the data port owns the current transaction
  logic               last_data;    // 1: the data port received the previous grant
  logic               ext_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        rdata_q;

  logic               gnt_instr, gnt_data, grant;
  logic [31:0]        req_addr;
  logic               req_we, req_ext;
  logic               timed_out, write_done;

  assign timed_out  = (cnt == CNT_W'(TIMEOUT));
  assign write_done = (cnt == CNT_W'(WRITE_CYCLES - 1));

  // Round-robin pick between the two ports and decode of the winning request
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (rst && (state == IDLE) && !set_programming_mode) begin
      if (instr_req && data_req) begin
        gnt_instr = last_data;
        gnt_data  = !last_data;
      end else if (instr_req) begin
        gnt_instr = 1'b1;
      end else if (data_req) begin
        gnt_data = 1'b1;
      end
    end
    grant    = gnt_instr | gnt_data;
    req_addr = gnt_data ? data_addr : instr_addr;
    req_we   = gnt_data & data_we;
    req_ext  = (req_addr >= SRAM_LIMIT);
  end

  // Control state: FSM state, ownership, round-robin history, error flag, counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      last_data  <= 1'b1;
      ext_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_data <= gnt_data;
        last_data  <= gnt_data;
        ext_q      <= req_ext;
        err_q      <= req_we & req_ext;
        cnt        <= '0;
      end else if ((state == READ_WAIT) || (state == WRITE_HOLD)) begin
        cnt <= cnt + 1'b1;
        if ((state == READ_WAIT) && !out_valid && timed_out) err_q <= 1'b1;
      end
    end
  end

  // Captured request fields and returned read data (qualified by state, so no reset needed)
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= req_addr;
      wdata_q <= data_wdata;
      be_q    <= gnt_data ? data_be : 4'hF;
      rdata_q <= '0;
    end else if ((state == READ_WAIT) && out_valid) begin
      rdata_q <= d_out;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          if (req_we && req_ext) state_nxt = RESP;
          else if (req_we)       state_nxt = WRITE_HOLD;
          else                   state_nxt = READ_WAIT;
        end
      end
      READ_WAIT:  if (out_valid || timed_out) state_nxt = RESP;
      WRITE_HOLD: if (write_done) state_nxt = RESP;
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output decode: grants, downstream access signals and the owner's response
  always_comb begin
    instr_gnt               = gnt_instr;
    data_gnt                = gnt_data;
    instr_rvalid            = 1'b0;
    instr_err               = 1'b0;
    instr_rdata             = '0;
    data_rvalid             = 1'b0;
    data_err                = 1'b0;
    data_rdata              = '0;
    memory_access           = 1'b0;
    memory_is_writing       = 1'b0;
    external_storage_access = 1'b0;
    addr                    = '0;
    d_in                    = '0;
    mem_be                  = '0;
    case (state)
      READ_WAIT: begin
        memory_access           = 1'b1;
        external_storage_access = ext_q;
        addr                    = addr_q;
        mem_be                  = be_q;
      end
      WRITE_HOLD: begin
        memory_access     = 1'b1;
        memory_is_writing = 1'b1;
        addr              = addr_q;
        d_in              = wdata_q;
        mem_be            = be_q;
      end
      RESP: begin
        if (owner_data) begin
          data_rvalid = 1'b1;
          data_err    = err_q;
          data_rdata  = rdata_q;
        end else begin
          instr_rvalid = 1'b1;
          instr_err    = err_q;
          instr_rdata  = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule
